// File: rtl/linear_proj_pkg.sv
// Shared state encoding and default sizing for the linear-projection controller.
// The weight address width covers one full job of reads at the default sizing.
package linear_proj_pkg;

  localparam int W_DEPTH_DEF    = 16;
  localparam int NUM_PASSES_DEF = 4;
  localparam int TIMEOUT_DEF    = 1024;
  localparam int ADDR_WIDTH_B   = $clog2(W_DEPTH_DEF * NUM_PASSES_DEF);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    WAIT,
    OUT,
    DONE,
    ERR
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == CLR) || (s == LOAD) || (s == WAIT) || (s == OUT);
  endfunction

endpackage

// File: rtl/linear_proj_addr_gen.sv
// Weight-BRAM read counter, tile index and registered read address; 1-cycle update.
// No backpressure: it steps only when the controller strobes it.
module linear_proj_addr_gen
  import linear_proj_pkg::*;
#(
  parameter int  W_DEPTH    = W_DEPTH_DEF,
  parameter int  NUM_PASSES = NUM_PASSES_DEF,
  localparam int PASS_W     = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load_start,
  input  logic                    load_step,
  input  logic                    pass_inc,
  output logic                    cnt_last,
  output logic                    pass_last,
  output logic [ADDR_WIDTH_B-1:0] addr,
  output logic [PASS_W-1:0]       pass_idx
);

  localparam int CNT_W = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;

  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH_B-1:0] base;

  // Truncation to the address width is the intended modulo wrap.
  assign base      = ADDR_WIDTH_B'(32'(pass_idx) * 32'(W_DEPTH));
  assign cnt_last  = (cnt == CNT_W'(W_DEPTH - 1));
  assign pass_last = (pass_idx == PASS_W'(NUM_PASSES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      addr     <= '0;
      pass_idx <= '0;
    end else if (clr) begin
      cnt      <= '0;
      addr     <= '0;
      pass_idx <= '0;
    end else begin
      if (load_start) begin
        cnt  <= '0;
        addr <= base;
      end else if (load_step) begin
        cnt  <= cnt + 1'b1;
        addr <= addr + 1'b1;
      end
      if (pass_inc) begin
        pass_idx <= pass_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/linear_proj_ctrl.sv
// Sequences clear/load/wait/output per tile of a Q/K/V projection job; Moore outputs, 1-cycle response.
// out_valid holds until out_ready; a WAIT watchdog parks the job in ERR until abort.
module linear_proj_ctrl
  import linear_proj_pkg::*;
#(
  parameter int  W_DEPTH    = W_DEPTH_DEF,
  parameter int  NUM_PASSES = NUM_PASSES_DEF,
  parameter int  TIMEOUT    = TIMEOUT_DEF,
  localparam int PASS_W     = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    acc_done_all,
  input  logic                    systolic_finish_all,
  input  logic                    out_ready,
  output logic                    en_module,
  output logic                    internal_rst_n,
  output logic                    internal_reset_acc,
  output logic                    w_mat_enb_q,
  output logic                    w_mat_enb_k,
  output logic                    w_mat_enb_v,
  output logic [ADDR_WIDTH_B-1:0] w_mat_addrb_q,
  output logic [ADDR_WIDTH_B-1:0] w_mat_addrb_k,
  output logic [ADDR_WIDTH_B-1:0] w_mat_addrb_v,
  output logic                    busy,
  output logic                    out_valid,
  output logic                    done,
  output logic                    error,
  output logic [PASS_W-1:0]       pass_idx
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t                  state, state_d;
  logic [WD_W-1:0]         wd;
  logic                    cnt_last, pass_last;
  logic                    clr, load_start, load_step, pass_inc;
  logic                    enb;
  logic [ADDR_WIDTH_B-1:0] addr;

  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_d = CLR;
        CLR:  state_d = LOAD;
        LOAD: if (cnt_last) state_d = WAIT;
        WAIT: begin
          if (acc_done_all && systolic_finish_all) state_d = OUT;
          else if (wd == WD_W'(TIMEOUT - 1))       state_d = ERR;
        end
        OUT:  if (out_ready) state_d = pass_last ? DONE : CLR;
        DONE: state_d = IDLE;
        ERR:  state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  assign clr        = (state_d == IDLE);
  assign load_start = (state == CLR) && (state_d == LOAD);
  assign load_step  = (state == LOAD) && (state_d == LOAD);
  assign pass_inc   = (state == OUT) && (state_d == CLR);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      wd                 <= '0;
      en_module          <= 1'b0;
      internal_rst_n     <= 1'b0;
      internal_reset_acc <= 1'b1;
      enb                <= 1'b0;
      busy               <= 1'b0;
      out_valid          <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
    end else begin
      state              <= state_d;
      wd                 <= (state == WAIT && state_d == WAIT) ? wd + 1'b1 : '0;
      en_module          <= (state_d == LOAD) || (state_d == WAIT) || (state_d == OUT);
      internal_rst_n     <= (state_d != CLR);
      internal_reset_acc <= (state_d == CLR);
      enb                <= (state_d == LOAD);
      busy               <= is_busy(state_d);
      out_valid          <= (state_d == OUT);
      done               <= (state_d == DONE);
      error              <= (state_d == ERR);
    end
  end

  linear_proj_addr_gen #(
    .W_DEPTH    (W_DEPTH),
    .NUM_PASSES (NUM_PASSES)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .load_start (load_start),
    .load_step  (load_step),
    .pass_inc   (pass_inc),
    .cnt_last   (cnt_last),
    .pass_last  (pass_last),
    .addr       (addr),
    .pass_idx   (pass_idx)
  );

  assign w_mat_enb_q   = enb;
  assign w_mat_enb_k   = enb;
  assign w_mat_enb_v   = enb;
  assign w_mat_addrb_q = addr;
  assign w_mat_addrb_k = addr;
  assign w_mat_addrb_v = addr;

endmodule

// File: tb/tb_linear_proj_ctrl.sv
// Randomized bench for linear_proj_ctrl: the driver queues expected reads/tiles/done pulses
// from the job rules, and a negedge monitor pops and compares whenever the DUT presents them.
module tb_linear_proj_ctrl;
  import linear_proj_pkg::*;

  localparam int W  = 16;
  localparam int NP = 4;
  localparam int TO = 1024;
  localparam int AW = ADDR_WIDTH_B;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, acc_done_all, systolic_finish_all, out_ready;
  logic          en_module, internal_rst_n, internal_reset_acc;
  logic          w_mat_enb_q, w_mat_enb_k, w_mat_enb_v;
  logic [AW-1:0] w_mat_addrb_q, w_mat_addrb_k, w_mat_addrb_v;
  logic          busy, out_valid, done, error;
  logic [PW-1:0] pass_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_addr[$];
  int exp_pass[$];
  int exp_done[$];
  int mon_e;

  always #5 clk = ~clk;

  linear_proj_ctrl #(
    .W_DEPTH    (W),
    .NUM_PASSES (NP),
    .TIMEOUT    (TO)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .abort               (abort),
    .acc_done_all        (acc_done_all),
    .systolic_finish_all (systolic_finish_all),
    .out_ready           (out_ready),
    .en_module           (en_module),
    .internal_rst_n      (internal_rst_n),
    .internal_reset_acc  (internal_reset_acc),
    .w_mat_enb_q         (w_mat_enb_q),
    .w_mat_enb_k         (w_mat_enb_k),
    .w_mat_enb_v         (w_mat_enb_v),
    .w_mat_addrb_q       (w_mat_addrb_q),
    .w_mat_addrb_k       (w_mat_addrb_k),
    .w_mat_addrb_v       (w_mat_addrb_v),
    .busy                (busy),
    .out_valid           (out_valid),
    .done                (done),
    .error               (error),
    .pass_idx            (pass_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_ctrl", {en_module, internal_rst_n, internal_reset_acc}, 3'b001);
    chk("rst_enb", {w_mat_enb_q, w_mat_enb_k, w_mat_enb_v}, 0);
    chk("rst_addr", {w_mat_addrb_q, w_mat_addrb_k, w_mat_addrb_v}, 0);
    chk("rst_status", {busy, out_valid, done, error}, 0);
    chk("rst_pass_idx", pass_idx, 0);
  endtask

  // Monitor: every read cycle, tile hand-off and done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (w_mat_enb_q) begin
        chk("enb_kv_match", {w_mat_enb_k, w_mat_enb_v}, 2'b11);
        chk("addr_k_match", w_mat_addrb_k, w_mat_addrb_q);
        chk("addr_v_match", w_mat_addrb_v, w_mat_addrb_q);
        chk("load_en_module", en_module, 1);
        chk("addr_pending", 32'(exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0) begin
          mon_e = exp_addr.pop_front();
          chk("load_addr", w_mat_addrb_q, mon_e);
        end
      end
      if (out_valid && out_ready) begin
        chk("tile_pending", 32'(exp_pass.size() != 0), 1);
        if (exp_pass.size() != 0) begin
          mon_e = exp_pass.pop_front();
          chk("tile_pass_idx", pass_idx, mon_e);
        end
        chk("tile_en_module", en_module, 1);
      end
      if (done) begin
        chk("done_pending", 32'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) mon_e = exp_done.pop_front();
        chk("done_quiet", {busy, out_valid, error}, 0);
      end
    end
  end

  // One job; abort_pass >= 0 cancels on the 8th read of that pass. delay/bp < 0 means random.
  task automatic run_job(input bit noise, input int delay, input int bp, input int abort_pass);
    int npass;
    npass = (abort_pass < 0) ? NP : abort_pass + 1;
    for (int p = 0; p < npass; p++) begin
      int nw;
      nw = (p == abort_pass) ? 8 : W;
      for (int c = 0; c < nw; c++) exp_addr.push_back((p * W + c) % (1 << AW));
      if (p != abort_pass) exp_pass.push_back(p);
    end
    if (abort_pass < 0) exp_done.push_back(1);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_outputs", {internal_rst_n, internal_reset_acc, en_module, w_mat_enb_q, busy}, 5'b01001);
    for (int p = 0; p < npass; p++) begin
      int n, d, b, r;
      n = 0;
      while (!w_mat_enb_q && n < 50) begin tick(); n++; end
      chk("load_reached", w_mat_enb_q, 1);
      n = 0;
      while (w_mat_enb_q && n < 2 * W) begin
        if (p == abort_pass && n == 7) begin
          start = 1'b0; acc_done_all = 1'b0; systolic_finish_all = 1'b0;
          abort = 1'b1;
          tick();
          abort = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_enb", {w_mat_enb_q, w_mat_enb_k, w_mat_enb_v}, 0);
          chk("abort_pass_idx", pass_idx, 0);
          chk("abort_addr", w_mat_addrb_q, 0);
          return;
        end
        if (noise) begin
          start               = 1'($urandom_range(0, 1));
          acc_done_all        = 1'($urandom_range(0, 1));
          systolic_finish_all = 1'($urandom_range(0, 1));
        end
        tick();
        n++;
      end
      start = 1'b0; acc_done_all = 1'b0; systolic_finish_all = 1'b0;
      chk("load_len", n, W);
      chk("wait_state", {busy, en_module, out_valid, w_mat_enb_q}, 4'b1100);

      d = (delay < 0) ? int'($urandom_range(0, 20)) : delay;
      repeat (d) begin
        if (noise) begin
          r = int'($urandom_range(0, 2));
          acc_done_all        = (r == 1);
          systolic_finish_all = (r == 2);
        end
        tick();
      end
      chk("wait_no_early_out", out_valid, 0);
      acc_done_all = 1'b1; systolic_finish_all = 1'b1;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      acc_done_all = 1'b0; systolic_finish_all = 1'b0;
      chk("out_latency", n, 1);

      b = (bp < 0) ? int'($urandom_range(0, 3)) : bp;
      for (int i = 0; i < b; i++) begin
        out_ready = 1'b0;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_pass_idx", pass_idx, p);
        chk("bp_en_module", en_module, 1);
        chk("bp_addr_frozen", w_mat_addrb_q, (p * W + W - 1) % (1 << AW));
        tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (p == NP - 1) begin
        chk("done_pulse", done, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", {busy, pass_idx}, 0);
      end else begin
        chk("next_pass_clr", {internal_reset_acc, busy, pass_idx}, {2'b11, PW'(p + 1)});
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    acc_done_all = 1'b0; systolic_finish_all = 1'b0; out_ready = 1'b0;
    #12;
    check_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_release", {internal_rst_n, internal_reset_acc, busy, en_module}, 4'b1000);

    run_job(1'b0, 5, 0, -1);
    run_job(1'b0, 3, 10, -1);
    repeat (6) run_job(1'b1, -1, -1, -1);
    run_job(1'b1, -1, -1, 2);
    run_job(1'b0, -1, -1, -1);

    // Watchdog: accumulation done but drain never finishes.
    for (int c = 0; c < W; c++) exp_addr.push_back(c);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!w_mat_enb_q && n < 50) begin tick(); n++; end
    n = 0;
    while (w_mat_enb_q && n < 2 * W) begin tick(); n++; end
    acc_done_all = 1'b1;
    n = 0;
    while (!error && n < TO + 100) begin tick(); n++; end
    chk("timeout_cycles", n, TO);
    chk("err_outputs", {error, busy, en_module, w_mat_enb_q, out_valid, done}, 6'b100000);
    systolic_finish_all = 1'b1; start = 1'b1;
    repeat (3) tick();
    chk("err_sticky", error, 1);
    start = 1'b0; acc_done_all = 1'b0; systolic_finish_all = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("err_abort", {error, busy, pass_idx}, 0);

    // Asynchronous reset in the middle of WAIT.
    for (int c = 0; c < W; c++) exp_addr.push_back(c);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!w_mat_enb_q && n < 50) begin tick(); n++; end
    n = 0;
    while (w_mat_enb_q && n < 2 * W) begin tick(); n++; end
    repeat (3) tick();
    chk("pre_reset_wait", {busy, en_module}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_rerelease", {internal_rst_n, internal_reset_acc, busy}, 3'b100);
    run_job(1'b1, -1, -1, -1);

    repeat (5) tick();
    chk("addr_queue_drained", exp_addr.size(), 0);
    chk("tile_queue_drained", exp_pass.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: run did not complete, %0d compared so far", n_cmp);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/linear_proj_ctrl.md
LINEAR_PROJ_CTRL -- requirements
Module: linear_proj_ctrl

Interface
REQ-001 SHALL have parameter W_DEPTH, default 16: weight-BRAM words read per pass (per-pass read count).
REQ-002 SHALL have parameter NUM_PASSES, default 4: output tiles per job (job length).
REQ-003 SHALL have parameter TIMEOUT, default 1024: max WAIT cycles before error.
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  job request, sampled in IDLE only.
REQ-007 SHALL have port abort  in  1  synchronous job cancel.
REQ-008 SHALL have port acc_done_all  in  1  accumulation complete, all Q/K/V engines.
REQ-009 SHALL have port systolic_finish_all  in  1  systolic drain complete, all engines.
REQ-010 SHALL have port out_ready  in  1  consumer accepts current tile.
REQ-011 SHALL have port en_module  out  1  datapath enable.
REQ-012 SHALL have port internal_rst_n  out  1  datapath soft reset, active-low.
REQ-013 SHALL have port internal_reset_acc  out  1  accumulator clear.
REQ-014 SHALL have ports w_mat_enb_q/_k/_v  out  1 each  weight-BRAM read enables.
REQ-015 SHALL have ports w_mat_addrb_q/_k/_v  out  ADDR_WIDTH_B each  weight-BRAM addresses.
REQ-016 SHALL have ports busy, out_valid, done, error  out  1 each  status/handshake.
REQ-017 SHALL have port pass_idx  out  clog2(NUM_PASSES)  current tile index.

Function
REQ-018 SHALL implement states IDLE, CLR, LOAD, WAIT, OUT, DONE, ERR.
REQ-019 IDLE: start=1 -> CLR next cycle; pass_idx=0; start ignored in every other state.
REQ-020 CLR: exactly 1 cycle; internal_rst_n=0, internal_reset_acc=1; en_module=0; enb=0; -> LOAD.
REQ-021 LOAD: exactly W_DEPTH cycles; en_module=1; all three enb=1; all three addr=pass_idx*W_DEPTH+cnt, cnt 0..W_DEPTH-1; -> WAIT.
REQ-022 Q, K, V enables and addresses SHALL be bit-identical every cycle.
REQ-023 Address SHALL be computed in ADDR_WIDTH_B bits and wrap modulo 2^ADDR_WIDTH_B; no overflow flag.
REQ-024 WAIT: en_module=1, enb=0; when acc_done_all & systolic_finish_all both 1 in same cycle -> OUT.
REQ-025 WAIT: watchdog counts from 0; reaching TIMEOUT without REQ-024 condition -> ERR.
REQ-026 OUT: out_valid=1, en_module=1; held until out_ready=1; out_valid SHALL NOT drop before acceptance.
REQ-027 OUT with out_ready=1: pass_idx<NUM_PASSES-1 -> pass_idx+1, CLR; else -> DONE.
REQ-028 DONE: done=1 for exactly 1 cycle, then IDLE.
REQ-029 ERR: error=1, all datapath enables 0; leaves only via abort=1 -> IDLE.
REQ-030 busy=1 in CLR, LOAD, WAIT, OUT; 0 in IDLE, DONE, ERR.
REQ-031 abort=1 in any state SHALL force IDLE next cycle, clear counters, no done pulse; abort beats out_ready/acc_done same cycle.
REQ-032 acc_done_all/systolic_finish_all outside WAIT SHALL be ignored.
REQ-033 All outputs SHALL be registered (Moore); response latency 1 cycle from input.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE; counters, pass_idx, watchdog = 0.
REQ-035 Reset values: en_module=0, internal_rst_n=0, internal_reset_acc=1, enb=0, addr=0, busy/out_valid/done/error=0.
REQ-036 After rst_n deasserts, internal_rst_n=1 and internal_reset_acc=0 on first clock in IDLE.
REQ-037 Reset mid-job SHALL discard the job; no done pulse.

Structure
REQ-038 State enum typedef and W_DEPTH/NUM_PASSES/TIMEOUT defaults SHALL reside in linear_proj_pkg; ADDR_WIDTH_B taken from it.
REQ-039 Single sub-module linear_proj_addr_gen (cnt, pass base, address) is natural; FSM stays in top.

Verification
REQ-040 start pulse, acc_done_all/systolic_finish_all high 5 cycles into WAIT, out_ready=1 -> addrs 0..15, 16..31, 32..47, 48..63, one done pulse, 4 out_valid.
REQ-041 out_ready held 0 for 10 cycles in OUT -> out_valid stays 1, addr/pass_idx frozen, en_module=1.
REQ-042 acc_done_all=1 but systolic_finish_all=0 through TIMEOUT=1024 -> error=1 at cycle 1024 of WAIT; abort -> IDLE, error=0.
REQ-043 abort asserted on LOAD cycle 7 of pass 2 -> IDLE next cycle, enb=0, no done; new start restarts at addr 0.
REQ-044 rst_n low mid-WAIT -> outputs at REQ-035 values immediately, without clock edge.
REQ-045 start while busy and acc_done_all pulsed during LOAD -> ignored; sequence and addresses unchanged.
